// File: rtl/sram_byte_arbiter_pkg.sv
// Shared types and constants for the byte-wide SRAM arbiter.
package sram_arb_pkg;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int LANES  = 4;
  localparam int BYTE_W = 8;

  localparam logic REQ_A = 1'b0;
  localparam logic REQ_B = 1'b1;

endpackage

// File: rtl/sram_byte_arbiter_if.sv
// Request/response bundle for the two byte-wide requesters A and B.
interface sram_byte_arbiter_if #(
  parameter int ADDR_W = 9
);
  logic              a_valid;
  logic              a_ready;
  logic              a_we;
  logic [ADDR_W+1:0] a_addr;
  logic [7:0]        a_wdata;
  logic              a_rvalid;
  logic [7:0]        a_rdata;

  logic              b_valid;
  logic              b_ready;
  logic              b_we;
  logic [ADDR_W+1:0] b_addr;
  logic [7:0]        b_wdata;
  logic              b_rvalid;
  logic [7:0]        b_rdata;

  modport master (
    output a_valid, a_we, a_addr, a_wdata,
    input  a_ready, a_rvalid, a_rdata,
    output b_valid, b_we, b_addr, b_wdata,
    input  b_ready, b_rvalid, b_rdata
  );

  modport slave (
    input  a_valid, a_we, a_addr, a_wdata,
    output a_ready, a_rvalid, a_rdata,
    input  b_valid, b_we, b_addr, b_wdata,
    output b_ready, b_rvalid, b_rdata
  );
endinterface

// File: rtl/sram_byte_arbiter_rr_arb2.sv
// Two-input round-robin arbiter with a last-grant pointer.
// Latency: combinational grant; pointer updates on the edge after a grant.
// Backpressure: no grant while en is low; a loser keeps requesting until granted.
module sram_rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  logic last_b_q;

  always_comb begin
    gnt = 2'b00;
    if (en) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = last_b_q ? 2'b01 : 2'b10;
        default: gnt = 2'b00;
      endcase
    end
  end

  // Pointer starts at B so that A wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_b_q <= 1'b1;
    end else if (|gnt) begin
      last_b_q <= gnt[1];
    end
  end

endmodule

// File: rtl/sram_byte_arbiter.sv
// Shares one 1RW 32-bit SRAM between two byte requesters; zero-fills it after reset.
// Latency: read byte returned one cycle after acceptance; writes have no response.
// Backpressure: ready only to the granted requester; both held off during the fill.
module sram_byte_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ADDR_W  = 9,
  parameter bit INIT_EN = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  sram_byte_arbiter_if.slave      bus,
  output logic                    init_done,
  output logic                    ram_clk0,
  output logic                    ram_csb0,
  output logic                    ram_web0,
  output logic [LANES-1:0]        ram_wmask0,
  output logic [ADDR_W-1:0]       ram_addr0,
  output logic [LANES*BYTE_W-1:0] ram_din0,
  input  logic [LANES*BYTE_W-1:0] ram_dout0
);

  localparam int DEPTH = 2 ** ADDR_W;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q;
  logic              fill_wr;
  logic [1:0]        gnt;
  logic              sel_b;
  logic              sel_we;
  logic [1:0]        sel_lane;
  logic [ADDR_W-1:0] sel_word;
  logic [BYTE_W-1:0] sel_wdata;
  logic              rd_vld_q;
  logic              rd_id_q;
  logic [1:0]        rd_lane_q;
  logic [BYTE_W-1:0] rd_byte;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fill_wr = 1'b0;
    case (state_q)
      INIT: begin
        if (INIT_EN) begin
          fill_wr = 1'b1;
          cnt_d   = cnt_q + ADDR_W'(1);
          if (cnt_q == ADDR_W'(DEPTH - 1)) begin
            state_d = RUN;
          end
        end else begin
          state_d = RUN;
        end
      end
      RUN:     state_d = RUN;
      default: state_d = INIT;
    endcase
  end

  assign init_done = (state_q == RUN);

  sram_rr_arb2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (state_q == RUN),
    .req   ({bus.b_valid, bus.a_valid}),
    .gnt   (gnt)
  );

  assign bus.a_ready = gnt[0];
  assign bus.b_ready = gnt[1];

  assign sel_b     = gnt[1];
  assign sel_we    = sel_b ? bus.b_we    : bus.a_we;
  assign sel_lane  = sel_b ? bus.b_addr[1:0] : bus.a_addr[1:0];
  assign sel_word  = sel_b ? bus.b_addr[ADDR_W+1:2] : bus.a_addr[ADDR_W+1:2];
  assign sel_wdata = sel_b ? bus.b_wdata : bus.a_wdata;

  assign ram_clk0 = clk;

  // Everything is gated by rst_n so the macro is deselected the instant reset asserts.
  always_comb begin
    ram_csb0   = 1'b1;
    ram_web0   = 1'b1;
    ram_wmask0 = '0;
    ram_addr0  = addr_q;
    ram_din0   = '0;
    if (rst_n) begin
      if (fill_wr) begin
        ram_csb0   = 1'b0;
        ram_web0   = 1'b0;
        ram_wmask0 = '1;
        ram_addr0  = cnt_q;
      end else if (|gnt) begin
        ram_csb0  = 1'b0;
        ram_addr0 = sel_word;
        if (sel_we) begin
          ram_web0   = 1'b0;
          ram_wmask0 = LANES'(1) << sel_lane;
          ram_din0   = {LANES{sel_wdata}};
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q    <= '0;
      rd_vld_q  <= 1'b0;
      rd_id_q   <= REQ_A;
      rd_lane_q <= '0;
    end else begin
      if (!ram_csb0) begin
        addr_q <= ram_addr0;
      end
      rd_vld_q <= (|gnt) && !sel_we;
      if ((|gnt) && !sel_we) begin
        rd_id_q   <= sel_b ? REQ_B : REQ_A;
        rd_lane_q <= sel_lane;
      end
    end
  end

  assign rd_byte      = ram_dout0[rd_lane_q*BYTE_W +: BYTE_W];
  assign bus.a_rvalid = rd_vld_q && (rd_id_q == REQ_A);
  assign bus.b_rvalid = rd_vld_q && (rd_id_q == REQ_B);
  assign bus.a_rdata  = bus.a_rvalid ? rd_byte : '0;
  assign bus.b_rdata  = bus.b_rvalid ? rd_byte : '0;

endmodule

// File: tb/tb_sram_byte_arbiter.sv
// Directed bench with a byte-level reference memory and a read-response scoreboard.
module tb_sram_byte_arbiter;
  import sram_arb_pkg::*;

  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sram_byte_arbiter_if #(.ADDR_W(AW)) bus ();
  sram_byte_arbiter_if #(.ADDR_W(AW)) bus1 ();

  logic          init_done, ram_clk0, ram_csb0, ram_web0;
  logic [3:0]    ram_wmask0;
  logic [AW-1:0] ram_addr0;
  logic [31:0]   ram_din0, ram_dout0;

  logic          init_done_1, ram_clk0_1, ram_csb0_1, ram_web0_1;
  logic [3:0]    ram_wmask0_1;
  logic [AW-1:0] ram_addr0_1;
  logic [31:0]   ram_din0_1;

  sram_byte_arbiter #(.ADDR_W(AW), .INIT_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave), .init_done(init_done),
    .ram_clk0(ram_clk0), .ram_csb0(ram_csb0), .ram_web0(ram_web0),
    .ram_wmask0(ram_wmask0), .ram_addr0(ram_addr0), .ram_din0(ram_din0),
    .ram_dout0(ram_dout0)
  );

  sram_byte_arbiter #(.ADDR_W(AW), .INIT_EN(1'b0)) dut_nofill (
    .clk(clk), .rst_n(rst_n), .bus(bus1.slave), .init_done(init_done_1),
    .ram_clk0(ram_clk0_1), .ram_csb0(ram_csb0_1), .ram_web0(ram_web0_1),
    .ram_wmask0(ram_wmask0_1), .ram_addr0(ram_addr0_1), .ram_din0(ram_din0_1),
    .ram_dout0(32'h0)
  );

  // Behavioural 1RW macro: masked write, registered read data.
  logic [31:0] mem [DEPTH];
  logic [31:0] wword;
  always @(posedge ram_clk0) begin
    if (!ram_csb0) begin
      if (!ram_web0) begin
        wword = mem[ram_addr0];
        for (int l = 0; l < 4; l++) begin
          if (ram_wmask0[l]) wword[l*8 +: 8] = ram_din0[l*8 +: 8];
        end
        mem[ram_addr0] <= wword;
      end else begin
        ram_dout0 <= mem[ram_addr0];
      end
    end
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  typedef struct packed {
    logic       id;
    logic [7:0] data;
  } exp_t;

  exp_t       exp_q [$];
  exp_t       e;
  logic [7:0] ref_mem [64];

  // Responses of the previous cycle are checked before this cycle's grants are recorded.
  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q.delete();
      for (int i = 0; i < 64; i++) ref_mem[i] = 8'h00;
    end else begin
      if (bus.a_rvalid || bus.b_rvalid) begin
        if (exp_q.size() == 0) begin
          chk("spurious_rvalid", {bus.a_rvalid, bus.b_rvalid}, 32'h0);
        end else begin
          e = exp_q.pop_front();
          chk("rsp_route", {bus.a_rvalid, bus.b_rvalid}, e.id ? 2'b01 : 2'b10);
          chk("rsp_data", e.id ? bus.b_rdata : bus.a_rdata, e.data);
        end
      end
      if (bus.a_ready || bus.b_ready) chk("one_grant", bus.a_ready & bus.b_ready, 1'b0);
      if (bus.a_valid && bus.a_ready) begin
        if (bus.a_we) ref_mem[bus.a_addr] = bus.a_wdata;
        else exp_q.push_back({1'b0, ref_mem[bus.a_addr]});
      end
      if (bus.b_valid && bus.b_ready) begin
        if (bus.b_we) ref_mem[bus.b_addr] = bus.b_wdata;
        else exp_q.push_back({1'b1, ref_mem[bus.b_addr]});
      end
    end
  end

  task automatic wait_rdy(input bit is_b, input string tag);
    int n = 0;
    @(negedge clk);
    while (!(is_b ? bus.b_ready : bus.a_ready) && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk(tag, is_b ? bus.b_ready : bus.a_ready, 1'b1);
  endtask

  task automatic fill_check(input int n, input bit with_nofill);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("fill_csb", ram_csb0, 1'b0);
      chk("fill_web", ram_web0, 1'b0);
      chk("fill_wmask", ram_wmask0, 4'hF);
      chk("fill_din", ram_din0, 32'h0);
      chk("fill_addr", ram_addr0, i[AW-1:0]);
      chk("fill_a_ready", bus.a_ready, 1'b0);
      chk("fill_a_rvalid", bus.a_rvalid, 1'b0);
      chk("fill_init_done", init_done, 1'b0);
      if (with_nofill) begin
        chk("nofill_csb", ram_csb0_1, 1'b1);
        chk("nofill_init_done", init_done_1, i != 0);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = 32'hDEADBEEF;
    for (int i = 0; i < 64; i++) ref_mem[i] = 8'h00;
    ram_dout0 = 32'h0;
    {bus.a_valid, bus.a_we, bus.a_addr, bus.a_wdata} = '0;
    {bus.b_valid, bus.b_we, bus.b_addr, bus.b_wdata} = '0;
    {bus1.a_valid, bus1.a_we, bus1.a_addr, bus1.a_wdata} = '0;
    {bus1.b_valid, bus1.b_we, bus1.b_addr, bus1.b_wdata} = '0;

    repeat (2) @(negedge clk);
    chk("rst_a_ready", bus.a_ready, 1'b0);
    chk("rst_rvalid", {bus.a_rvalid, bus.b_rvalid}, 2'b00);
    chk("rst_rdata", {bus.a_rdata, bus.b_rdata}, 16'h0);
    chk("rst_init_done", {init_done, init_done_1}, 2'b00);
    chk("rst_csb", ram_csb0, 1'b1);
    chk("rst_web", ram_web0, 1'b1);
    chk("rst_wmask", ram_wmask0, 4'h0);

    // A write is presented during the fill and must wait for it.
    bus.a_valid = 1'b1; bus.a_we = 1'b1; bus.a_addr = 6'h06; bus.a_wdata = 8'hA5;
    @(posedge clk); #1 rst_n = 1'b1;
    fill_check(DEPTH, 1'b1);
    @(negedge clk);
    chk("init_done_rise", init_done, 1'b1);
    chk("wr_a_ready", bus.a_ready, 1'b1);
    chk("wr_csb", ram_csb0, 1'b0);
    chk("wr_web", ram_web0, 1'b0);
    chk("wr_wmask", ram_wmask0, 4'b0100);
    chk("wr_addr", ram_addr0, 4'd1);
    chk("wr_din", ram_din0, 32'hA5A5A5A5);

    @(posedge clk); #1 bus.a_we = 1'b0;
    @(negedge clk);
    chk("rd_a_ready", bus.a_ready, 1'b1);
    chk("rd_web", ram_web0, 1'b1);
    chk("rd_wmask", ram_wmask0, 4'h0);
    @(posedge clk); #1 bus.a_addr = 6'h07;
    @(negedge clk);
    chk("rd06_rvalid", bus.a_rvalid, 1'b1);
    chk("rd06_rdata", bus.a_rdata, 8'hA5);
    @(posedge clk); #1 bus.a_valid = 1'b0;
    @(negedge clk);
    chk("idle_csb", ram_csb0, 1'b1);
    chk("rd07_rvalid", bus.a_rvalid, 1'b1);
    chk("rd07_rdata", bus.a_rdata, 8'h00);
    @(negedge clk);
    chk("rvalid_pulse", bus.a_rvalid, 1'b0);

    // B write leaves the pointer at B, so the tie sequence starts with A.
    @(posedge clk); #1 bus.b_valid = 1'b1; bus.b_we = 1'b1; bus.b_addr = 6'h0D; bus.b_wdata = 8'h3C;
    wait_rdy(1'b1, "b_wr_ready");
    chk("b_wr_wmask", ram_wmask0, 4'b0010);
    @(posedge clk); #1
    bus.a_valid = 1'b1; bus.a_we = 1'b0; bus.a_addr = 6'h0D;
    bus.b_we = 1'b0; bus.b_addr = 6'h06;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("alt_a_ready", bus.a_ready, (k % 2) == 0);
      chk("alt_b_ready", bus.b_ready, (k % 2) == 1);
      if (k > 0) chk("alt_b_rvalid", bus.b_rvalid, (k % 2) == 0);
      @(posedge clk); #1;
    end
    bus.a_valid = 1'b0; bus.b_valid = 1'b0;
    repeat (2) @(negedge clk);

    // Read-after-write across requesters in consecutive cycles.
    @(posedge clk); #1 bus.a_valid = 1'b1; bus.a_we = 1'b1; bus.a_addr = 6'h10; bus.a_wdata = 8'h77;
    wait_rdy(1'b0, "raw_a_ready");
    @(posedge clk); #1 bus.a_valid = 1'b0; bus.b_valid = 1'b1; bus.b_we = 1'b0; bus.b_addr = 6'h10;
    @(negedge clk);
    chk("raw_b_ready", bus.b_ready, 1'b1);
    @(posedge clk); #1 bus.b_valid = 1'b0;
    @(negedge clk);
    chk("raw_b_rvalid", bus.b_rvalid, 1'b1);
    chk("raw_b_rdata", bus.b_rdata, 8'h77);

    // Reset during run, then again part-way through the fill.
    @(posedge clk); #1 rst_n = 1'b0;
    #1 chk("rst_run_csb", ram_csb0, 1'b1);
    @(posedge clk); #1 rst_n = 1'b1;
    fill_check(5, 1'b0);
    @(posedge clk); #1 rst_n = 1'b0;
    #1 chk("rst_fill_csb", ram_csb0, 1'b1);
    @(posedge clk); #1 rst_n = 1'b1;
    fill_check(DEPTH, 1'b0);
    @(negedge clk);
    chk("refill_done", init_done, 1'b1);

    // Reset with a read in flight: its response must never appear.
    bus.a_valid = 1'b1; bus.a_we = 1'b0; bus.a_addr = 6'h10;
    wait_rdy(1'b0, "flight_a_ready");
    @(posedge clk); #1 rst_n = 1'b0; bus.a_valid = 1'b0;
    #1 chk("flight_csb", ram_csb0, 1'b1);
    chk("flight_rvalid", bus.a_rvalid, 1'b0);
    @(posedge clk); #1 rst_n = 1'b1;
    fill_check(DEPTH, 1'b0);
    @(negedge clk);
    chk("flight_done", init_done, 1'b1);

    @(posedge clk); #1 bus.b_valid = 1'b1; bus.b_we = 1'b0; bus.b_addr = 6'h0D;
    wait_rdy(1'b1, "post_b_ready");
    @(posedge clk); #1 bus.b_valid = 1'b0;
    @(negedge clk);
    chk("post_b_rdata", bus.b_rdata, 8'h00);
    repeat (2) @(negedge clk);
    chk("scoreboard_empty", exp_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
